video_line_fetch: RTL and testbench
===================================

# video_line_fetch

Pixel fetch stage sitting directly downstream of the video sync generator. Prefetches frame-buffer words from a memory read port into an internal FIFO and pops one pixel per active pixel tick. Emits pixel data aligned with delayed sync/blank, ready for the DAC/HDMI encoder. Restarts at the frame base address after every frame, so the next frame is fetched during vertical blanking.

## Interface
- AW, 20: memory word address width
- DW, 16: pixel/memory data width
- FRAME_WORDS, 307200: pixels (words) per frame, H_RES*V_RES
- FCW, 19: frame word counter width, 2^FCW > FRAME_WORDS
- FIFO_AW, 9: FIFO address width, depth 2^FIFO_AW
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- clk_en  in  1  pixel clock enable, video side only; memory side runs every clk
- en  in  1  block enable
- fb_base  in  AW  frame base word address
- active  in  1  from sync gen, pixel is active
- blank  in  1  from sync gen
- a_end  in  1  from sync gen, last active pixel of frame
- h_sync_in  in  1  from sync gen
- v_sync_in  in  1  from sync gen
- mem_req  out  1  read request, address valid
- mem_addr  out  AW  read word address
- mem_ack  in  1  request accepted this clk
- mem_rdata  in  DW  read data
- mem_rvalid  in  1  read data valid, in-order returns
- pix_data  out  DW  output pixel
- h_sync  out  1  delayed h sync
- v_sync  out  1  delayed v sync
- pix_blank  out  1  delayed blank
- underflow  out  1  sticky, FIFO empty on an active pop
- fifo_level  out  FIFO_AW+1  current FIFO occupancy

## Operation
- Fetcher: word counter wcnt (FCW bits), base register, outstanding counter ocnt (FIFO_AW+1 bits), drop counter dcnt (FIFO_AW+1 bits).
- mem_req = en && wcnt < FRAME_WORDS && (fifo_level + ocnt) < 2^FIFO_AW && !restart. mem_addr = base + wcnt, truncated to AW.
- Acceptance: mem_req && mem_ack -> wcnt+1, ocnt+1. mem_rvalid -> ocnt-1. Accept and return in the same clk -> ocnt unchanged.
- mem_rvalid with dcnt==0 -> write mem_rdata to FIFO. With dcnt!=0 -> discard, dcnt-1.
- The credit rule makes FIFO overflow impossible. A write into a full FIFO is a design error; assert it in sim.
- Restart event: clk_en && a_end && en, or en rising edge.
  - Next clk: wcnt=0, base=fb_base, FIFO flushed (level 0), dcnt=ocnt (minus any rvalid in that clk), ocnt=0.
  - mem_req deasserts during the restart clk.
- Consumer, on clk_en:
  - active && en && FIFO non-empty -> pop, pix_data=head.
  - active && en && FIFO empty -> pix_data=0, underflow set.
  - otherwise pix_data=0.
- Sync delay, on clk_en: h_sync<=h_sync_in, v_sync<=v_sync_in, pix_blank<=blank||!en. Polarity passes through unchanged.
- underflow clears only on rst.
- en low: mem_req=0, FIFO held flushed, pix_data=0, pix_blank=1. Returns still in flight are dropped via dcnt.
- A pop and a write in the same clk leave fifo_level unchanged. Pops only occur on clk_en.

## Timing
- Reset values: all outputs 0; wcnt, ocnt, dcnt, FIFO pointers 0; base=0. Fetching starts on the en rising edge after reset.
- mem_req/mem_addr are registered. After a restart, the first mem_req appears 2 clk later. Address advances the clk after acceptance.
- Memory read latency is any value ≥1 clk. Returns are strictly in order.
- FIFO write to readable: 1 clk.
- pix_data, h_sync, v_sync and pix_blank all update on the same clk_en tick, one tick after the sync-gen inputs. They stay mutually aligned.
- Reset mid-operation clears everything immediately. Late mem_rvalid pulses arriving after rst deassertion with ocnt==0 are ignored and must not underflow ocnt.

## Test plan
- Basic frame, FRAME_WORDS=8, FIFO_AW=3, clk_en=1, 2-clk memory latency, rdata=addr, fb_base=0x100, 8 active ticks then a_end -> pix_data 0x100..0x107 in order. No underflow. mem_addr restarts at 0x100 after a_end.
- Credit limit, FIFO_AW=2, no pops, 10-clk latency -> at most 4 accepted requests, fifo_level saturates at 4, mem_req low thereafter.
- Underflow: mem_ack held 0, active for 3 ticks -> pix_data=0 for those ticks, underflow=1 and stays 1 after mem_ack resumes.
- Restart with in-flight data: a_end while ocnt=3 -> those 3 returns dropped. First pixel of next frame = word at new fb_base=0x200.
- Alignment with clk_en every 4th clk: toggle h_sync_in, v_sync_in, blank -> outputs change exactly one clk_en tick later, together with pix_data.
- en low mid-frame, then high -> mem_req=0 and pix_blank=1 while low. On re-enable, fetch restarts at fb_base with fifo_level=0.

Source files
------------

// File: rtl/video_line_fetch.sv
// video_line_fetch: prefetches frame-buffer words into a FIFO and emits one
// pixel per active pixel tick, aligned with the delayed sync/blank outputs.
// The memory side runs every clk. The video side advances on clk_en only.
module video_line_fetch #(
    parameter int AW          = 20,
    parameter int DW          = 16,
    parameter int FRAME_WORDS = 307200,
    parameter int FCW         = 19,
    parameter int FIFO_AW     = 9
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               clk_en,
    input  logic               en,
    input  logic [AW-1:0]      fb_base,
    input  logic               active,
    input  logic               blank,
    input  logic               a_end,
    input  logic               h_sync_in,
    input  logic               v_sync_in,
    output logic               mem_req,
    output logic [AW-1:0]      mem_addr,
    input  logic               mem_ack,
    input  logic [DW-1:0]      mem_rdata,
    input  logic               mem_rvalid,
    output logic [DW-1:0]      pix_data,
    output logic               h_sync,
    output logic               v_sync,
    output logic               pix_blank,
    output logic               underflow,
    output logic [FIFO_AW:0]   fifo_level
);

    localparam int DEPTH = 1 << FIFO_AW;
    localparam int CW    = FIFO_AW + 1;

    typedef logic [CW-1:0] cnt_t;
    typedef logic [CW:0]   sum_t;

    // Fetcher state
    logic [FCW-1:0]     wcnt, wcnt_n;
    logic [AW-1:0]      base, base_n;
    cnt_t               ocnt, ocnt_n;   // live requests whose data will be kept
    cnt_t               dcnt, dcnt_n;   // requests whose data belongs to an abandoned frame
    cnt_t               level_n;
    sum_t               credit_used;
    logic               req_n;
    logic               en_q;

    // FIFO state
    logic [FIFO_AW-1:0] wr_ptr, rd_ptr;
    logic [DW-1:0]      fifo_mem [DEPTH];

    // Event decode
    logic restart, flush, accept, rv_live, rv_drop, fifo_wr, fifo_pop, fifo_empty;

    // A new frame starts after the last active pixel or when the block is enabled.
    // While disabled the FIFO is held flushed, in the same way as on a restart.
    assign restart    = en && ((clk_en && a_end) || !en_q);
    assign flush      = restart || !en;
    assign accept     = mem_req && mem_ack;
    // Returns owed to an abandoned frame are discarded first. A return that
    // arrives with nothing outstanding, such as one left over from before a
    // reset, is ignored.
    assign rv_drop    = mem_rvalid && (dcnt != '0);
    assign rv_live    = mem_rvalid && (dcnt == '0) && (ocnt != '0);
    assign fifo_wr    = rv_live;
    assign fifo_empty = (fifo_level == '0);
    assign fifo_pop   = clk_en && active && en && !fifo_empty;

    // Next-state values for the fetcher. The registered request is derived from
    // these values, so it never overshoots the credit limit or the frame end.
    // NOTE: every signal gets a default at the top of the block, so no path can leave it unassigned and infer a latch.
    always_comb begin
        wcnt_n  = wcnt + FCW'(accept);
        base_n  = base;
        ocnt_n  = ocnt + cnt_t'(accept) - cnt_t'(rv_live);
        dcnt_n  = dcnt - cnt_t'(rv_drop);
        level_n = fifo_level + cnt_t'(fifo_wr) - cnt_t'(fifo_pop);
        if (flush) begin
            wcnt_n  = '0;
            base_n  = fb_base;
            level_n = '0;
            // Everything still in flight, including an acceptance in this
            // clk, now belongs to the abandoned frame.
            dcnt_n  = dcnt_n + ocnt_n;
            ocnt_n  = '0;
        end
        credit_used = {1'b0, level_n} + {1'b0, ocnt_n};
        req_n = en && !restart
                && (wcnt_n < FCW'(FRAME_WORDS))
                && (credit_used < sum_t'(DEPTH));
    end

    // Fetcher registers, request outputs and FIFO pointers.
    // NOTE: sequential state uses non-blocking assignments, so every register samples pre-edge values regardless of block order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            en_q       <= 1'b0;
            wcnt       <= '0;
            base       <= '0;
            ocnt       <= '0;
            dcnt       <= '0;
            fifo_level <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            mem_req    <= 1'b0;
            mem_addr   <= '0;
        end else begin
            en_q       <= en;
            wcnt       <= wcnt_n;
            base       <= base_n;
            ocnt       <= ocnt_n;
            dcnt       <= dcnt_n;
            fifo_level <= level_n;
            mem_req    <= req_n;
            mem_addr   <= base_n + AW'(wcnt_n);
            if (flush) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
            end else begin
                if (fifo_wr)  wr_ptr <= wr_ptr + 1'b1;
                if (fifo_pop) rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

    // FIFO storage, written with each kept memory return.
    // NOTE: the storage array has no reset; the pointers and level define which entries are valid.
    always_ff @(posedge clk) begin
        if (fifo_wr) fifo_mem[wr_ptr] <= mem_rdata;
    end

    // Video side: pixel pop plus sync/blank delay, all on the same clk_en tick.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pix_data  <= '0;
            h_sync    <= 1'b0;
            v_sync    <= 1'b0;
            pix_blank <= 1'b0;
            underflow <= 1'b0;
        end else if (clk_en) begin
            pix_data  <= fifo_pop ? fifo_mem[rd_ptr] : '0;
            h_sync    <= h_sync_in;
            v_sync    <= v_sync_in;
            pix_blank <= blank || !en;
            if (active && en && fifo_empty) underflow <= 1'b1;
        end
    end

    // The credit rule must keep a kept return from ever landing in a full FIFO.
    always_ff @(posedge clk) begin
        if (!rst && fifo_wr && !fifo_pop && !flush)
            assert (fifo_level != cnt_t'(DEPTH));
    end

endmodule

// File: tb/tb_video_line_fetch.sv
// Directed testbench for video_line_fetch. It uses a small frame (8 words) and
// a 4-deep FIFO. A behavioural memory returns rdata = address after a
// programmable latency.
module tb_video_line_fetch;

    localparam int AW      = 20;
    localparam int DW      = 16;
    localparam int FW      = 8;
    localparam int FCW     = 4;
    localparam int FIFO_AW = 2;

    logic              clk = 1'b0;
    logic              rst, clk_en, en;
    logic [AW-1:0]     fb_base;
    logic              active, blank, a_end, h_sync_in, v_sync_in;
    logic              mem_req;
    logic [AW-1:0]     mem_addr;
    logic              mem_ack;
    logic [DW-1:0]     mem_rdata  = '0;
    logic              mem_rvalid = 1'b0;
    logic [DW-1:0]     pix_data;
    logic              h_sync, v_sync, pix_blank, underflow;
    logic [FIFO_AW:0]  fifo_level;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    video_line_fetch #(
        .AW(AW), .DW(DW), .FRAME_WORDS(FW), .FCW(FCW), .FIFO_AW(FIFO_AW)
    ) dut (
        .clk(clk), .rst(rst), .clk_en(clk_en), .en(en), .fb_base(fb_base),
        .active(active), .blank(blank), .a_end(a_end),
        .h_sync_in(h_sync_in), .v_sync_in(v_sync_in),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack),
        .mem_rdata(mem_rdata), .mem_rvalid(mem_rvalid),
        .pix_data(pix_data), .h_sync(h_sync), .v_sync(v_sync),
        .pix_blank(pix_blank), .underflow(underflow), .fifo_level(fifo_level)
    );

    // Behavioural memory: in-order returns, latency counted in clk edges.
    typedef struct { logic [AW-1:0] addr; int due; } rd_t;
    rd_t rq[$];
    int  cyc     = 0;
    int  lat     = 2;
    int  acc_cnt = 0;

    always @(posedge clk) begin
        cyc++;
        if (mem_req === 1'b1 && mem_ack === 1'b1) begin
            rq.push_back('{addr: mem_addr, due: cyc + lat});
            acc_cnt++;
        end
        if (rq.size() > 0 && rq[0].due <= cyc + 1) begin
            mem_rvalid <= 1'b1;
            mem_rdata  <= DW'(rq[0].addr);
            void'(rq.pop_front());
        end else begin
            mem_rvalid <= 1'b0;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_req(input int max, input string tag);
        for (int k = 0; k < max && mem_req !== 1'b1; k++) @(negedge clk);
        check(tag, 32'(mem_req), 32'd1);
    endtask

    task automatic wait_level(input int lvl, input int max, input string tag);
        for (int k = 0; k < max && fifo_level !== 3'(lvl); k++) @(negedge clk);
        check(tag, 32'(fifo_level), 32'(lvl));
    endtask

    task automatic wait_acc(input int acc0, input int n, input int max, input string tag);
        for (int k = 0; k < max && (acc_cnt - acc0) != n; k++) @(negedge clk);
        check(tag, 32'(acc_cnt - acc0), 32'(n));
    endtask

    initial begin
        int acc0;
        rst = 1'b1; clk_en = 1'b1; en = 1'b0; fb_base = 20'h100;
        active = 1'b0; blank = 1'b0; a_end = 1'b0; h_sync_in = 1'b0; v_sync_in = 1'b0;
        mem_ack = 1'b1;

        // Reset state
        step(3);
        check("rst_mem_req",   32'(mem_req),    32'd0);
        check("rst_mem_addr",  32'(mem_addr),   32'd0);
        check("rst_pix_data",  32'(pix_data),   32'd0);
        check("rst_h_sync",    32'(h_sync),     32'd0);
        check("rst_v_sync",    32'(v_sync),     32'd0);
        check("rst_pix_blank", 32'(pix_blank),  32'd0);
        check("rst_underflow", 32'(underflow),  32'd0);
        check("rst_level",     32'(fifo_level), 32'd0);
        rst = 1'b0;
        step(2);

        // Basic frame: prefill, then 8 active ticks with a_end on the last
        en = 1'b1;
        wait_level(4, 20, "fill_basic");
        for (int i = 0; i < 8; i++) begin
            active = 1'b1; a_end = (i == 7);
            step(1);
            check($sformatf("frame_px%0d", i), 32'(pix_data), 32'h100 + i);
        end
        active = 1'b0; a_end = 1'b0;
        check("frame_no_underflow", 32'(underflow), 32'd0);
        wait_req(10, "req_after_aend");
        check("addr_after_aend", 32'(mem_addr), 32'h100);

        // en low mid-frame, then credit limit on re-enable with long latency
        lat = 10; en = 1'b0; fb_base = 20'h140;
        step(3);
        check("en_low_req",   32'(mem_req),    32'd0);
        check("en_low_blank", 32'(pix_blank),  32'd1);
        check("en_low_level", 32'(fifo_level), 32'd0);
        acc0 = acc_cnt; en = 1'b1;
        wait_req(10, "req_reenable");
        check("addr_reenable",  32'(mem_addr),   32'h140);
        check("level_reenable", 32'(fifo_level), 32'd0);
        step(5);
        check("credit_acc_early",   32'(acc_cnt - acc0), 32'd4);
        check("credit_level_early", 32'(fifo_level),     32'd0);
        check("credit_req_low",     32'(mem_req),        32'd0);
        step(15);
        check("credit_acc_final", 32'(acc_cnt - acc0), 32'd4);
        check("credit_level_sat", 32'(fifo_level),     32'd4);
        check("credit_req_final", 32'(mem_req),        32'd0);

        // Underflow: memory stalled, 3 active ticks on an empty FIFO
        mem_ack = 1'b0; en = 1'b0;
        step(1);
        en = 1'b1;
        step(3);
        check("uf_level_empty", 32'(fifo_level), 32'd0);
        for (int i = 0; i < 3; i++) begin
            active = 1'b1;
            step(1);
            check($sformatf("uf_px%0d", i), 32'(pix_data), 32'd0);
        end
        active = 1'b0;
        check("uf_set", 32'(underflow), 32'd1);
        mem_ack = 1'b1; lat = 2;
        step(12);
        check("uf_sticky", 32'(underflow),  32'd1);
        check("uf_refill", 32'(fifo_level), 32'd4);

        // Restart with three requests in flight: their data must be dropped
        lat = 10; en = 1'b0;
        step(1);
        acc0 = acc_cnt; en = 1'b1;
        wait_acc(acc0, 3, 20, "inflight_acc");
        fb_base = 20'h200; a_end = 1'b1;
        step(1);
        a_end = 1'b0;
        check("inflight_flush", 32'(fifo_level), 32'd0);
        wait_req(10, "req_new_frame");
        check("addr_new_frame", 32'(mem_addr), 32'h200);
        wait_level(4, 30, "fill_new_frame");
        active = 1'b1;
        step(1);
        active = 1'b0;
        check("first_px_new_frame", 32'(pix_data), 32'h200);
        step(1);
        check("idle_px_zero", 32'(pix_data), 32'd0);

        // Alignment: outputs move together only on a clk_en tick
        clk_en = 1'b0; h_sync_in = 1'b1; v_sync_in = 1'b1; blank = 1'b1; active = 1'b1;
        step(3);
        check("align_hold_hs", 32'(h_sync),   32'd0);
        check("align_hold_px", 32'(pix_data), 32'd0);
        clk_en = 1'b1;
        step(1);
        clk_en = 1'b0;
        check("align_hs",    32'(h_sync),    32'd1);
        check("align_vs",    32'(v_sync),    32'd1);
        check("align_blank", 32'(pix_blank), 32'd1);
        check("align_px",    32'(pix_data),  32'h201);
        h_sync_in = 1'b0; v_sync_in = 1'b0; blank = 1'b0; active = 1'b0;
        step(3);
        check("align_hold2_hs", 32'(h_sync),   32'd1);
        check("align_hold2_px", 32'(pix_data), 32'h201);
        clk_en = 1'b1;
        step(1);
        check("align_hs_fall",    32'(h_sync),    32'd0);
        check("align_vs_fall",    32'(v_sync),    32'd0);
        check("align_blank_fall", 32'(pix_blank), 32'd0);
        check("align_px_fall",    32'(pix_data),  32'd0);

        // Reset mid-operation; late returns arrive with nothing outstanding
        lat = 10; fb_base = 20'h300; en = 1'b0;
        step(1);
        acc0 = acc_cnt; en = 1'b1;
        wait_acc(acc0, 3, 20, "pre_rst_acc");
        rst = 1'b1; en = 1'b0;
        step(1);
        check("midrst_level", 32'(fifo_level), 32'd0);
        check("midrst_req",   32'(mem_req),    32'd0);
        check("midrst_uf",    32'(underflow),  32'd0);
        rst = 1'b0;
        step(15);
        check("late_rv_level", 32'(fifo_level), 32'd0);
        en = 1'b1;
        wait_level(4, 30, "fill_after_rst");
        active = 1'b1;
        step(1);
        active = 1'b0;
        check("px_after_rst", 32'(pix_data), 32'h300);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL watchdog: observed no finish, required finish before 50000");
        $fatal(1, "watchdog");
    end

endmodule
